// File: rtl/snake_body_ctrl.sv
// Snake movement and body store: steps the head once per STEP_CYCLES, handles
// direction keys, growth and collisions, and answers renderer cell queries.
module snake_body_ctrl #(
    parameter int STEP_CYCLES = 12_500_000,
    parameter int MAX_LEN     = 16,
    parameter int INIT_X      = 10,
    parameter int INIT_Y      = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_start,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       add_cube,
    output logic [5:0] head_x,
    output logic [5:0] head_y,
    output logic [4:0] length,
    output logic       step_pulse,
    output logic       game_over,
    input  logic [5:0] q_x,
    input  logic [4:0] q_y,
    output logic       q_head,
    output logic       q_body
);

    localparam int                CNT_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [4:0]        LEN_MAX  = 5'(MAX_LEN);
    localparam logic [4:0]        LEN_INIT = 5'd3;
    localparam logic [5:0]        X0       = 6'(INIT_X);
    localparam logic [4:0]        Y0       = 5'(INIT_Y);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DEAD} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    state_t           r_state, w_state_nxt;
    dir_t             r_cur_dir, r_next_dir, w_key_dir;
    logic [CNT_W-1:0] r_cnt;
    logic [5:0]       r_seg_x [MAX_LEN];
    logic [4:0]       r_seg_y [MAX_LEN];
    logic [4:0]       r_len;
    logic             r_grow_pend, r_add_prev, r_step_pulse, r_q_head, r_q_body;

    logic             w_key_valid, w_key_ok, w_add_edge;
    logic             w_eval, w_step, w_restart;
    logic             w_grow, w_wall, w_self, w_hit;
    logic [5:0]       w_nh_x;
    logic [4:0]       w_nh_y;
    logic [4:0]       w_chk_len;
    logic             w_q_head, w_q_body;

    function automatic logic f_opposite(input dir_t a, input dir_t b);
        case (a)
            DIR_UP:    return b == DIR_DOWN;
            DIR_DOWN:  return b == DIR_UP;
            DIR_LEFT:  return b == DIR_RIGHT;
            default:   return b == DIR_LEFT;
        endcase
    endfunction

    function automatic logic [5:0] f_init_x(input int unsigned i);
        return (i < 3) ? X0 - 6'(i) : '0;
    endfunction

    function automatic logic [4:0] f_init_y(input int unsigned i);
        return (i < 3) ? Y0 : '0;
    endfunction

    assign w_add_edge = add_cube & ~r_add_prev;

    always_comb begin
        w_key_valid = 1'b1;
        w_key_dir   = DIR_RIGHT;
        if (key_up)          w_key_dir = DIR_UP;
        else if (key_down)   w_key_dir = DIR_DOWN;
        else if (key_left)   w_key_dir = DIR_LEFT;
        else if (key_right)  w_key_dir = DIR_RIGHT;
        else                 w_key_valid = 1'b0;
        w_key_ok = w_key_valid && !f_opposite(r_cur_dir, w_key_dir);
    end

    always_comb begin
        w_nh_x = r_seg_x[0];
        w_nh_y = r_seg_y[0];
        case (r_next_dir)
            DIR_UP:    w_nh_y = r_seg_y[0] - 5'd1;
            DIR_DOWN:  w_nh_y = r_seg_y[0] + 5'd1;
            DIR_LEFT:  w_nh_x = r_seg_x[0] - 6'd1;
            default:   w_nh_x = r_seg_x[0] + 6'd1;
        endcase
        w_wall = (w_nh_x == 6'd0) || (w_nh_x == 6'd39) || (w_nh_y == 5'd0) || (w_nh_y == 5'd29);
        w_grow = r_grow_pend && (r_len < LEN_MAX);
        // the tail cell is vacated by this move unless the snake grows
        w_chk_len = w_grow ? r_len : r_len - 5'd1;
        w_self = 1'b0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (5'(i) < w_chk_len && r_seg_x[i] == w_nh_x && r_seg_y[i] == w_nh_y)
                w_self = 1'b1;
        end
        w_hit = w_wall || w_self;
    end

    always_comb begin
        w_q_head = (q_x == r_seg_x[0]) && (q_y == r_seg_y[0]);
        w_q_body = 1'b0;
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
            if (5'(i) < r_len && q_x == r_seg_x[i] && q_y == r_seg_y[i])
                w_q_body = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_eval      = 1'b0;
        w_step      = 1'b0;
        w_restart   = 1'b0;
        game_over   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (game_start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_eval = 1'b1;
                    if (w_hit) w_state_nxt = ST_DEAD;
                    else       w_step      = 1'b1;
                end
            end
            ST_DEAD: begin
                game_over = 1'b1;
                if (game_start) begin
                    w_restart   = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_cur_dir    <= DIR_RIGHT;
            r_next_dir   <= DIR_RIGHT;
            r_len        <= LEN_INIT;
            r_grow_pend  <= 1'b0;
            r_add_prev   <= 1'b0;
            r_step_pulse <= 1'b0;
            r_q_head     <= 1'b0;
            r_q_body     <= 1'b0;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= f_init_x(i);
                r_seg_y[i] <= f_init_y(i);
            end
        end else begin
            r_add_prev   <= add_cube;
            r_step_pulse <= w_step;
            r_q_head     <= w_q_head;
            r_q_body     <= w_q_body;
            if (w_restart) begin
                r_cnt       <= '0;
                r_cur_dir   <= DIR_RIGHT;
                r_next_dir  <= DIR_RIGHT;
                r_len       <= LEN_INIT;
                r_grow_pend <= 1'b0;
                for (int unsigned i = 0; i < MAX_LEN; i++) begin
                    r_seg_x[i] <= f_init_x(i);
                    r_seg_y[i] <= f_init_y(i);
                end
            end else begin
                if (r_state == ST_RUN)
                    r_cnt <= w_eval ? '0 : r_cnt + 1'b1;
                // a step consumes the pending growth; an edge in that same cycle re-arms it
                if (w_eval)          r_grow_pend <= w_add_edge;
                else if (w_add_edge) r_grow_pend <= 1'b1;
                if (w_key_ok)
                    r_next_dir <= w_key_dir;
                if (w_step) begin
                    r_cur_dir  <= r_next_dir;
                    r_seg_x[0] <= w_nh_x;
                    r_seg_y[0] <= w_nh_y;
                    for (int unsigned i = 1; i < MAX_LEN; i++) begin
                        r_seg_x[i] <= r_seg_x[i-1];
                        r_seg_y[i] <= r_seg_y[i-1];
                    end
                    if (w_grow) r_len <= r_len + 5'd1;
                end
            end
        end
    end

    assign head_x     = r_seg_x[0];
    assign head_y     = {1'b0, r_seg_y[0]};
    assign length     = r_len;
    assign step_pulse = r_step_pulse;
    assign q_head     = r_q_head;
    assign q_body     = r_q_body;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Bench for snake_body_ctrl: directed scenarios then random play, every cycle
// compared against a queue-based model of the snake.
module tb_snake_body_ctrl;

    localparam int STEP = 8;
    localparam int MAXL = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       game_start = 1'b0;
    logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
    logic       add_cube = 1'b0;
    logic [5:0] q_x = '0;
    logic [4:0] q_y = '0;
    logic [5:0] head_x, head_y;
    logic [4:0] length;
    logic       step_pulse, game_over, q_head, q_body;

    always #5 clk = ~clk;

    snake_body_ctrl #(
        .STEP_CYCLES(STEP),
        .MAX_LEN    (MAXL),
        .INIT_X     (10),
        .INIT_Y     (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .game_start(game_start),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_left  (key_left),
        .key_right (key_right),
        .add_cube  (add_cube),
        .head_x    (head_x),
        .head_y    (head_y),
        .length    (length),
        .step_pulse(step_pulse),
        .game_over (game_over),
        .q_x       (q_x),
        .q_y       (q_y),
        .q_head    (q_head),
        .q_body    (q_body)
    );

    int errors = 0;
    int checks = 0;

    // Model: body as coordinate queues, head at the front; directions as (dx,dy).
    int sx[$], sy[$];
    int m_mode;
    int m_cnt, m_cdx, m_cdy, m_ndx, m_ndy;
    bit m_grow, m_add_prev;
    bit e_sp, e_qh, e_qb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_init_snake();
        sx = {10, 9, 8};
        sy = {10, 10, 10};
        m_cdx = 1; m_cdy = 0;
        m_ndx = 1; m_ndy = 0;
        m_grow = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_reset();
        model_init_snake();
        m_mode = 0;
        m_add_prev = 1'b0;
        e_sp = 1'b0; e_qh = 1'b0; e_qb = 1'b0;
    endtask

    task automatic model_tick();
        int  kdx, kdy, nx, ny, lim;
        bit  kv, edge_, grow, hit;
        e_qh = (int'(q_x) == sx[0]) && (int'(q_y) == sy[0]);
        e_qb = 1'b0;
        for (int i = 1; i < sx.size(); i++)
            if (int'(q_x) == sx[i] && int'(q_y) == sy[i]) e_qb = 1'b1;
        e_sp = 1'b0;
        edge_ = add_cube && !m_add_prev;
        m_add_prev = add_cube;
        kv = 1'b1; kdx = 0; kdy = 0;
        if (key_up)         kdy = -1;
        else if (key_down)  kdy = 1;
        else if (key_left)  kdx = -1;
        else if (key_right) kdx = 1;
        else                kv = 1'b0;
        if (kv && kdx == -m_cdx && kdy == -m_cdy) kv = 1'b0;
        case (m_mode)
            0: begin
                if (edge_) m_grow = 1'b1;
                if (game_start) m_mode = 1;
            end
            1: begin
                if (m_cnt == STEP - 1) begin
                    m_cnt = 0;
                    nx = sx[0] + m_ndx;
                    ny = sy[0] + m_ndy;
                    grow = m_grow && (sx.size() < MAXL);
                    hit = (nx == 0) || (nx == 39) || (ny == 0) || (ny == 29);
                    lim = grow ? sx.size() : sx.size() - 1;
                    for (int i = 0; i < lim; i++)
                        if (sx[i] == nx && sy[i] == ny) hit = 1'b1;
                    if (hit) begin
                        m_mode = 2;
                    end else begin
                        sx.push_front(nx);
                        sy.push_front(ny);
                        if (!grow) begin
                            void'(sx.pop_back());
                            void'(sy.pop_back());
                        end
                        m_cdx = m_ndx; m_cdy = m_ndy;
                        e_sp = 1'b1;
                    end
                    m_grow = edge_;
                end else begin
                    m_cnt++;
                    if (edge_) m_grow = 1'b1;
                end
            end
            default: begin
                if (edge_) m_grow = 1'b1;
                if (game_start) begin
                    model_init_snake();
                    m_mode = 1;
                    kv = 1'b0;
                end
            end
        endcase
        if (kv) begin
            m_ndx = kdx; m_ndy = kdy;
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".head_x"},     head_x,     sx[0]);
        chk({ph, ".head_y"},     head_y,     sy[0]);
        chk({ph, ".length"},     length,     sx.size());
        chk({ph, ".step_pulse"}, step_pulse, e_sp);
        chk({ph, ".game_over"},  game_over,  m_mode == 2);
        chk({ph, ".q_head"},     q_head,     e_qh);
        chk({ph, ".q_body"},     q_body,     e_qb);
    endtask

    string phase = "init";

    task automatic cycle();
        @(posedge clk);
        model_tick();
        #1;
        check_all(phase);
    endtask

    task automatic clear_keys();
        key_up = 1'b0; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0;
    endtask

    initial begin
        int r, idx;
        model_reset();
        #1 rst = 1'b0;
        #3;
        phase = "reset";
        check_all(phase);
        chk("reset.head_x_const", head_x, 10);
        chk("reset.length_const", length, 3);
        @(negedge clk);
        rst = 1'b1;

        phase = "query";
        q_x = 6'd9; q_y = 5'd10;
        cycle();
        chk("query.tail_body", q_body, 1);
        chk("query.tail_nothead", q_head, 0);
        q_x = 6'd10; q_y = 5'd10;
        cycle();
        chk("query.head", q_head, 1);

        phase = "run";
        game_start = 1'b1;
        cycle();
        game_start = 1'b0;
        repeat (16) cycle();
        chk("run.head_x_12", head_x, 12);
        chk("run.length_3", length, 3);

        phase = "keys";
        key_left = 1'b1;
        cycle();
        key_left = 1'b0;
        key_up = 1'b1;
        cycle();
        key_up = 1'b0;
        repeat (6) cycle();
        chk("keys.head_x", head_x, 12);
        chk("keys.head_y", head_y, 9);

        phase = "grow";
        add_cube = 1'b1;
        q_x = 6'd11; q_y = 5'd10;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (i == 8) chk("grow.old_tail_body", q_body, 1);
        end
        add_cube = 1'b0;
        chk("grow.length_4", length, 4);
        repeat (30) cycle();
        chk("grow.top_wall_dead", game_over, 1);
        chk("grow.frozen_y", head_y, 1);

        phase = "wall";
        game_start = 1'b1;
        cycle();
        game_start = 1'b0;
        chk("wall.restart_x", head_x, 10);
        repeat (240) cycle();
        chk("wall.head_x_38", head_x, 38);
        chk("wall.dead", game_over, 1);
        chk("wall.no_pulse", step_pulse, 0);

        phase = "self";
        game_start = 1'b1;
        cycle();
        game_start = 1'b0;
        add_cube = 1'b1;
        repeat (4) cycle();
        add_cube = 1'b0;
        repeat (8) cycle();
        add_cube = 1'b1;
        repeat (4) cycle();
        add_cube = 1'b0;
        chk("self.length_5", length, 5);
        key_up = 1'b1;   cycle(); clear_keys(); repeat (7) cycle();
        key_left = 1'b1; cycle(); clear_keys(); repeat (7) cycle();
        key_down = 1'b1; cycle(); clear_keys(); repeat (7) cycle();
        chk("self.dead", game_over, 1);
        chk("self.length_kept", length, 5);
        chk("self.head_x", head_x, 11);
        game_start = 1'b1;
        cycle();
        game_start = 1'b0;
        chk("self.restart_x", head_x, 10);
        chk("self.restart_y", head_y, 10);
        chk("self.restart_len", length, 3);
        chk("self.restart_alive", game_over, 0);

        phase = "random";
        for (int n = 0; n < 3000; n++) begin
            clear_keys();
            r = $urandom_range(0, 15);
            key_up    = (r == 0) || (r == 4);
            key_down  = (r == 1);
            key_left  = (r == 2) || (r == 4);
            key_right = (r == 3);
            if ($urandom_range(0, 19) == 0) add_cube = ~add_cube;
            game_start = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, sx.size() - 1);
                q_x = 6'(sx[idx]);
                q_y = 5'(sy[idx]);
            end else begin
                q_x = 6'($urandom_range(0, 39));
                q_y = 5'($urandom_range(0, 29));
            end
            if (n == 1500) begin
                rst = 1'b0;
                #2;
                model_reset();
                check_all("midreset");
                chk("midreset.idle", game_over, 0);
                rst = 1'b1;
            end
            cycle();
        end
        clear_keys();
        game_start = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snake_body_ctrl.md
Name: snake_body_ctrl

Overview:
Snake movement and body store for the Snake game. It sits directly ahead of the apple generator: it produces head_x/head_y and consumes that block's add_cube grow request. It advances the snake one grid cell per step tick, applies direction keys and growth, detects wall and self collisions, and answers per-cell occupancy queries from the VGA renderer.

Parameters:
STEP_CYCLES, 12_500_000, clk cycles per movement step (0.25 s at 50 MHz); benches use a small value such as 8.
MAX_LEN, 16, maximum number of body segments, including the head.
INIT_X, 10, head x after reset or restart.
INIT_Y, 10, head y after reset or restart.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
game_start  in  1  one-cycle pulse that starts or restarts a game
key_up  in  1  one-cycle direction pulse
key_down  in  1  one-cycle direction pulse
key_left  in  1  one-cycle direction pulse
key_right  in  1  one-cycle direction pulse
add_cube  in  1  grow request level from the apple generator
head_x  out  6  head column, 0..39
head_y  out  6  head row, 0..29; upper bit always 0
length  out  5  current segment count, 3..MAX_LEN
step_pulse  out  1  high for one cycle in the cycle after each committed move
game_over  out  1  high while in DEAD
q_x  in  6  query column
q_y  in  5  query row
q_head  out  1  queried cell holds the head (1-cycle latency)
q_body  out  1  queried cell holds a non-head segment (1-cycle latency)

Behaviour:
- Grid: walls are x=0, x=39, y=0, y=29. Playable cells are x 1..38, y 1..28.
- Storage: seg_x[i], seg_y[i] for i = 0..MAX_LEN-1. seg[0] is the head. Only i < length is active.
- Reset and init values:
  - state IDLE, length 3, direction RIGHT.
  - seg0 = (INIT_X, INIT_Y), seg1 = (INIT_X-1, INIT_Y), seg2 = (INIT_X-2, INIT_Y).
  - grow_pend 0, step counter 0.
  - step_pulse, game_over, q_head, q_body all 0.
- States:
  - IDLE: no movement, step counter held at 0. game_start moves to RUN.
  - RUN: the step counter counts 0..STEP_CYCLES-1. On the wrap cycle a step is evaluated.
  - DEAD: positions frozen, game_over=1. game_start reloads the init values, clears grow_pend and the counter, and moves to RUN in the same edge.
  - game_start in RUN is ignored.
- Direction:
  - A key pulse latches next_dir. If several keys fire in one cycle, priority is up > down > left > right.
  - A key that opposes cur_dir (the direction of the last committed move) is ignored.
  - next_dir is copied to cur_dir at each step.
  - Keys are accepted in every state; keys in DEAD are discarded on restart.
- Growth:
  - The rising edge of add_cube (registered previous value) sets grow_pend. add_cube is held high for many cycles, so it is edge-detected and never level-counted.
  - Several edges between two steps produce only one growth.
  - At a step with grow_pend=1 and length<MAX_LEN: the tail is kept, length increments, grow_pend clears.
  - At length==MAX_LEN: grow_pend clears and nothing changes.
- Step evaluation:
  - nh = seg0 moved one cell in next_dir.
  - Wall hit when nh.x is 0 or 39, or nh.y is 0 or 29.
  - Self hit when nh equals any seg[i]. The range checked is i < length-1 when not growing, and i < length when growing, because the vacating tail is legal only without growth.
  - On a hit: state becomes DEAD, segments are unchanged, and step_pulse is not asserted.
  - Otherwise: seg[i] <= seg[i-1] for all i ≥ 1, seg0 <= nh, and step_pulse=1 on the next cycle.
- head_x/head_y are always registered copies of seg0.
- Query: q_head and q_body are registered from the current q_x/q_y against the active segments, with 1-cycle latency and no stall. In IDLE and DEAD they still report the frozen snake.
- Reset asserted mid-game returns everything to the init values immediately. Reset has priority over all inputs.

Test Plan:
- Reset, then game_start, STEP_CYCLES=8, no keys → head steps (11,10), (12,10), … at 8-cycle intervals; step_pulse once per move; length=3.
- At head (12,10) moving right, pulse key_left, then key_up → left ignored; next head (12,9).
- Hold add_cube high 50 cycles spanning two steps → length becomes 4 after the first step only; old tail cell still reports q_body=1.
- Drive right from (10,10) for 28 steps → head reaches (38,10); the next step enters DEAD, game_over=1, head stays (38,10), no step_pulse.
- Grow to length 5, then up, left, down in successive steps → self hit, DEAD; game_start → head (10,10), length 3, RUN.
- Query q=(9,10) after reset → q_body=1, q_head=0 one cycle later; q=(10,10) → q_head=1.
